// File: rtl/adc_serial_pkg.sv
// adc_serial_pkg
//   Shared definitions for the multi-channel serial ADC reader.
//   - adc_state_e : frame sequencer states
//   - ADC_OUT_W   : per-channel width of the published sample word
//   - cnt_w()     : width of a counter that must hold the values 0..n-1
package adc_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } adc_state_e;

    localparam int ADC_OUT_W = 16;

    // Never returns less than 1 so a degenerate count still gives a legal vector.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// adc_sck_gen
//   Serial clock generator for one ADC frame. While en is high it divides
//   clk_100 into an SCK that starts low and toggles every SCK_DIV cycles.
//   sck is a plain register output, never a gated clock.
//
//   Ports
//     clk_100    in   system clock
//     reset      in   synchronous, active-high
//     en         in   high for the whole shift window; low forces sck=0
//     sck        out  registered serial clock
//     sck_rise   out  this clk_100 edge drives sck 0->1
//     sck_fall   out  this clk_100 edge drives sck 1->0 (sdo sampling edge)
//     shift_done out  this edge is the FRAME_BITS-th fall
module adc_sck_gen
    import adc_serial_pkg::*;
#(
    parameter int SCK_DIV    = 1,
    parameter int FRAME_BITS = 13
) (
    input  logic clk_100,
    input  logic reset,
    input  logic en,
    output logic sck,
    output logic sck_rise,
    output logic sck_fall,
    output logic shift_done
);

    localparam int DIV_W = cnt_w(SCK_DIV);
    localparam int BIT_W = cnt_w(FRAME_BITS);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             half_end;

    // The strobes are decoded from the current register state, so they are
    // high in the cycle whose closing edge performs the transition.
    always_comb begin
        half_end   = en && (div_cnt == DIV_W'(SCK_DIV - 1));
        sck_rise   = half_end && !sck;
        sck_fall   = half_end && sck;
        shift_done = sck_fall && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    end

    always_ff @(posedge clk_100) begin
        if (reset || !en) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sck     <= 1'b0;
        end else begin
            if (half_end) begin
                div_cnt <= '0;
                sck     <= ~sck;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (sck_fall)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_serial_multi.sv
// adc_serial_multi
//   Multi-channel reader for LTC2315-class serial ADCs. One SCK/CS pair is
//   shared by CH_NUM converters; all SDO lines are shifted in parallel and
//   published as zero-extended 16-bit words with a one-cycle valid strobe.
//
//   Frame: CONV (cs high, CONV_CYC cycles) -> SHIFT (cs low, FRAME_BITS sck
//   periods) -> DONE (one cycle). Frames repeat while start is high; start
//   is only looked at in IDLE and DONE.
//
//   Ports
//     clk_100           in   system clock
//     reset             in   synchronous, active-high
//     start             in   level enable for repeated frames
//     sck               out  serial clock, idles low
//     cs                out  chip select / conversion start, active low
//     sdo               in   one serial data bit per channel
//     busy              out  high in CONV, SHIFT and DONE
//     data_valid        out  high in the DONE cycle, adc_data just updated
//     adc_data          out  channel k at [16k+15:16k], zero-extended
//     adc_data_trigger  out  per-channel rising-step trigger flag
//
//   Build option
//     ADC_SERIAL_TRIG_EN : when defined, per-channel thresholds and the
//                          trigger compare are built; otherwise the trigger
//                          outputs are tied to 0 and TRIG_STEP is ignored.
module adc_serial_multi
    import adc_serial_pkg::*;
#(
    parameter int CH_NUM    = 2,
    parameter int DATA_W    = 12,
    parameter int LEAD_BITS = 1,
    parameter int SCK_DIV   = 1,
    parameter int CONV_CYC  = 4,
    parameter int TRIG_STEP = 32
) (
    input  logic                          clk_100,
    input  logic                          reset,
    input  logic                          start,
    output logic                          sck,
    output logic                          cs,
    input  logic [CH_NUM-1:0]             sdo,
    output logic                          busy,
    output logic                          data_valid,
    output logic [ADC_OUT_W*CH_NUM-1:0]   adc_data,
    output logic [CH_NUM-1:0]             adc_data_trigger
);

    localparam int FRAME_BITS = LEAD_BITS + DATA_W;
    localparam int CONV_W     = cnt_w(CONV_CYC);

    adc_state_e        state, nxt_state;
    logic [CONV_W-1:0] conv_cnt;
    logic              conv_end;
    logic              shift_en;
    logic              sck_rise;
    logic              sck_fall;
    logic              shift_done;

    // ------------------------------------------------------------------
    // Serial clock
    // ------------------------------------------------------------------
    adc_sck_gen #(
        .SCK_DIV    (SCK_DIV),
        .FRAME_BITS (FRAME_BITS)
    ) u_sck_gen (
        .clk_100    (clk_100),
        .reset      (reset),
        .en         (shift_en),
        .sck        (sck),
        .sck_rise   (sck_rise),
        .sck_fall   (sck_fall),
        .shift_done (shift_done)
    );

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100) begin
        if (reset)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    assign conv_end = (conv_cnt == CONV_W'(CONV_CYC - 1));

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (start)      nxt_state = CONV;
            CONV:    if (conv_end)   nxt_state = SHIFT;
            SHIFT:   if (shift_done) nxt_state = DONE;
            DONE:    nxt_state = start ? CONV : IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        cs       = 1'b1;
        busy     = 1'b0;
        shift_en = 1'b0;
        case (state)
            CONV:    busy = 1'b1;
            SHIFT: begin
                cs       = 1'b0;
                busy     = 1'b1;
                shift_en = 1'b1;
            end
            DONE:    busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (reset || state != CONV)
            conv_cnt <= '0;
        else
            conv_cnt <= conv_cnt + 1'b1;
    end

    // Data is registered on the edge that leaves SHIFT, so the strobe and the
    // new words are both visible throughout the DONE cycle.
    always_ff @(posedge clk_100) begin
        if (reset)
            data_valid <= 1'b0;
        else
            data_valid <= shift_done;
    end

    // ------------------------------------------------------------------
    // Per-channel capture and trigger
    // ------------------------------------------------------------------
    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        logic [DATA_W-1:0]    shreg;
        logic [DATA_W-1:0]    word;    // shreg plus the bit sampled this edge
        logic [ADC_OUT_W-1:0] data_q;
        logic                 trig_q;

        // Every sck fall shifts; the LEAD_BITS leading bits simply fall off
        // the top, leaving the last DATA_W bits after the final fall.
        if (DATA_W == 1) begin : g_w1
            assign word = sdo[k];
        end else begin : g_wn
            assign word = {shreg[DATA_W-2:0], sdo[k]};
        end

        always_ff @(posedge clk_100) begin
            if (reset)
                shreg <= '0;
            else if (sck_fall)
                shreg <= word;
        end

        always_ff @(posedge clk_100) begin
            if (reset)
                data_q <= '0;
            else if (shift_done)
                data_q <= ADC_OUT_W'(word);
        end

`ifdef ADC_SERIAL_TRIG_EN
        localparam logic [DATA_W:0] STEP = (DATA_W + 1)'(TRIG_STEP);

        logic [DATA_W-1:0] thr_q;
        logic [DATA_W:0]   sum;
        logic [DATA_W-1:0] thr_next;

        // One extra bit catches the carry so the new threshold saturates at
        // full scale instead of wrapping to a small value.
        always_comb begin
            sum      = {1'b0, word} + STEP;
            thr_next = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
        end

        always_ff @(posedge clk_100) begin
            if (reset) begin
                thr_q  <= '0;
                trig_q <= 1'b0;
            end else if (shift_done) begin
                trig_q <= (word > thr_q);
                thr_q  <= thr_next;
            end
        end
`else
        assign trig_q = 1'b0;
`endif

        assign adc_data[k*ADC_OUT_W +: ADC_OUT_W] = data_q;
        assign adc_data_trigger[k]               = trig_q;
    end

endmodule

// File: tb/tb_adc_serial_multi.sv
// tb_adc_serial_multi
//   Directed bench for adc_serial_multi. Instance a uses default parameters,
//   instance b uses SCK_DIV=3, DATA_W=14, LEAD_BITS=2. Each instance has a
//   small ADC model: leading zeros then the data word MSB first, advancing
//   one bit per sck fall. Trigger expectations follow ADC_SERIAL_TRIG_EN.
module tb_adc_serial_multi;

`ifdef ADC_SERIAL_TRIG_EN
    localparam bit TRIG_ON = 1'b1;
`else
    localparam bit TRIG_ON = 1'b0;
`endif

    logic clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    logic        reset   = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;

    logic        sck_a, cs_a, busy_a, dv_a;
    logic [1:0]  sdo_a = '0;
    logic [1:0]  trig_a;
    logic [31:0] data_a;

    logic        sck_b, cs_b, busy_b, dv_b;
    logic [1:0]  sdo_b = '0;
    logic [1:0]  trig_b;
    logic [31:0] data_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] word_a [2];
    logic [15:0] word_b [2];
    int          idx_a = 0, idx_b = 0;
    logic        prv_a = 1'b0, prv_b = 1'b0;

    adc_serial_multi u_dut_a (
        .clk_100 (clk_100), .reset (reset), .start (start_a),
        .sck (sck_a), .cs (cs_a), .sdo (sdo_a), .busy (busy_a),
        .data_valid (dv_a), .adc_data (data_a), .adc_data_trigger (trig_a)
    );

    adc_serial_multi #(
        .CH_NUM (2), .DATA_W (14), .LEAD_BITS (2), .SCK_DIV (3),
        .CONV_CYC (4), .TRIG_STEP (32)
    ) u_dut_b (
        .clk_100 (clk_100), .reset (reset), .start (start_b),
        .sck (sck_b), .cs (cs_b), .sdo (sdo_b), .busy (busy_b),
        .data_valid (dv_b), .adc_data (data_b), .adc_data_trigger (trig_b)
    );

    function automatic logic model_bit(input logic [15:0] w, input int idx,
                                       input int dw, input int lead);
        if (idx < lead || idx >= lead + dw) return 1'b0;
        return w[dw - 1 - (idx - lead)];
    endfunction

    // ADC models, updated on the falling clk edge so sdo is stable at the
    // DUT's sampling edge.
    always @(negedge clk_100) begin
        if (cs_a) idx_a = 0;
        else if (prv_a && !sck_a) idx_a = idx_a + 1;
        prv_a = sck_a;
        for (int k = 0; k < 2; k++) sdo_a[k] = model_bit(word_a[k], idx_a, 12, 1);
        if (cs_b) idx_b = 0;
        else if (prv_b && !sck_b) idx_b = idx_b + 1;
        prv_b = sck_b;
        for (int k = 0; k < 2; k++) sdo_b[k] = model_bit(word_b[k], idx_b, 14, 2);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk_100);
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk_100);
        reset = 1'b0;
    endtask

    task automatic wait_dv_a(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_100);
            if (dv_a) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_dv_b(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_100);
            if (dv_b) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_100);
        n_tests++; if (cs_a !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b want 1", cs_a); end
        n_tests++; if (sck_a !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b want 0", sck_a); end
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_tests++; if (dv_a !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b want 0", dv_a); end
        n_tests++; if (data_a !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_a); end
        n_tests++; if (trig_a !== 2'b00) begin n_fail++; $display("FAIL reset_trig: got %b want 00", trig_a); end
    endtask

    task automatic test_basic();
        bit ok;
        int cyc, rises;
        logic prev;
        do_reset();
        word_a[0] = 16'h0ABC; word_a[1] = 16'h0123;
        start_a = 1'b1;
        wait_dv_a(100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_dv_timeout: got none want data_valid"); end
        n_tests++; if (data_a !== 32'h0123_0ABC) begin n_fail++; $display("FAIL basic_data: got %h want 01230abc", data_a); end
        n_tests++; if (trig_a !== (TRIG_ON ? 2'b11 : 2'b00)) begin n_fail++; $display("FAIL basic_trig: got %b want %b", trig_a, TRIG_ON ? 2'b11 : 2'b00); end
        cyc = 0; rises = 0; prev = sck_a;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_100);
            cyc++;
            if (sck_a && !prev) rises++;
            prev = sck_a;
            if (dv_a) break;
        end
        n_tests++; if (cyc !== 31) begin n_fail++; $display("FAIL basic_period: got %0d want 31", cyc); end
        n_tests++; if (rises !== 13) begin n_fail++; $display("FAIL basic_sck_periods: got %0d want 13", rises); end
        n_tests++; if (data_a !== 32'h0123_0ABC) begin n_fail++; $display("FAIL basic_data2: got %h want 01230abc", data_a); end
        @(negedge clk_100);
        n_tests++; if (dv_a !== 1'b0) begin n_fail++; $display("FAIL basic_dv_width: got %b want 0", dv_a); end
        start_a = 1'b0;
    endtask

    task automatic test_div3();
        bit ok;
        int cyc, rises, hi, cslow, run, bad;
        logic prev;
        do_reset();
        word_b[0] = 16'h2ABC; word_b[1] = 16'h1357;
        start_b = 1'b1;
        wait_dv_b(300, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL div3_dv_timeout: got none want data_valid"); end
        n_tests++; if (data_b !== 32'h1357_2ABC) begin n_fail++; $display("FAIL div3_data: got %h want 13572abc", data_b); end
        n_tests++; if (trig_b !== (TRIG_ON ? 2'b11 : 2'b00)) begin n_fail++; $display("FAIL div3_trig: got %b want %b", trig_b, TRIG_ON ? 2'b11 : 2'b00); end
        word_b[0] = 16'h3FFF; word_b[1] = 16'h0001;
        cyc = 0; rises = 0; hi = 0; cslow = 0; run = 0; bad = 0; prev = sck_b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_100);
            cyc++;
            if (!cs_b) cslow++;
            if (sck_b) begin hi++; run++; end
            if (sck_b && !prev) rises++;
            if (!sck_b && prev) begin if (run != 3) bad++; run = 0; end
            prev = sck_b;
            if (dv_b) break;
        end
        n_tests++; if (cyc !== 101) begin n_fail++; $display("FAIL div3_period: got %0d want 101", cyc); end
        n_tests++; if (rises !== 16) begin n_fail++; $display("FAIL div3_sck_periods: got %0d want 16", rises); end
        n_tests++; if (hi !== 48) begin n_fail++; $display("FAIL div3_high_cycles: got %0d want 48", hi); end
        n_tests++; if (cslow !== 96) begin n_fail++; $display("FAIL div3_cs_low: got %0d want 96", cslow); end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL div3_half_period: got %0d bad runs want 0", bad); end
        n_tests++; if (data_b !== 32'h0001_3FFF) begin n_fail++; $display("FAIL div3_data_full: got %h want 00013fff", data_b); end
        start_b = 1'b0;
    endtask

    // thr chain ch0: 0 ->132 ->152 ->165 ->4095 ->4095 (step 32, saturating)
    // thr chain ch1: 0 ->39  ->39  ->38  ->4032 ->4095
    task automatic test_trigger();
        logic [15:0] s0 [5];
        logic [15:0] s1 [5];
        logic [1:0]  et [5];
        logic [1:0]  want;
        bit ok;
        s0 = '{16'd100, 16'd120, 16'd133, 16'd4090, 16'd4095};
        s1 = '{16'd7,   16'd7,   16'd6,   16'd4000, 16'd4095};
        et = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b10};
        do_reset();
        word_a[0] = s0[0]; word_a[1] = s1[0];
        start_a = 1'b1;
        for (int f = 0; f < 5; f++) begin
            wait_dv_a(100, ok);
            want = TRIG_ON ? et[f] : 2'b00;
            n_tests++; if (!ok) begin n_fail++; $display("FAIL trig_dv_timeout[%0d]: got none want data_valid", f); end
            n_tests++; if (data_a !== {s1[f], s0[f]}) begin n_fail++; $display("FAIL trig_data[%0d]: got %h want %h", f, data_a, {s1[f], s0[f]}); end
            n_tests++; if (trig_a !== want) begin n_fail++; $display("FAIL trig_flag[%0d]: got %b want %b", f, trig_a, want); end
            if (f < 4) begin word_a[0] = s0[f+1]; word_a[1] = s1[f+1]; end
            if (f == 3) begin
                repeat (10) @(negedge clk_100);
                n_tests++; if (trig_a !== want) begin n_fail++; $display("FAIL trig_hold: got %b want %b", trig_a, want); end
            end
        end
        start_a = 1'b0;
    endtask

    task automatic test_stop_mid();
        bit ok, low;
        int extra_dv, bad_idle;
        do_reset();
        word_a[0] = 16'h0F0F; word_a[1] = 16'h0A5A;
        start_a = 1'b1;
        low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_100);
            if (!cs_a) begin low = 1'b1; break; end
        end
        n_tests++; if (!low) begin n_fail++; $display("FAIL stop_cs_timeout: got no cs low want cs low"); end
        repeat (5) @(negedge clk_100);
        start_a = 1'b0;
        wait_dv_a(100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stop_dv_timeout: got none want data_valid"); end
        n_tests++; if (data_a !== 32'h0A5A_0F0F) begin n_fail++; $display("FAIL stop_data: got %h want 0a5a0f0f", data_a); end
        extra_dv = 0; bad_idle = 0;
        @(negedge clk_100);
        for (int i = 0; i < 60; i++) begin
            if (dv_a) extra_dv++;
            if (cs_a !== 1'b1 || sck_a !== 1'b0 || busy_a !== 1'b0) bad_idle++;
            @(negedge clk_100);
        end
        n_tests++; if (extra_dv !== 0) begin n_fail++; $display("FAIL stop_extra_dv: got %0d want 0", extra_dv); end
        n_tests++; if (bad_idle !== 0) begin n_fail++; $display("FAIL stop_idle: got %0d non-idle cycles want 0", bad_idle); end
    endtask

    task automatic test_reset_mid();
        bit ok, hit;
        int falls;
        logic prev;
        do_reset();
        word_a[0] = 16'h05A5; word_a[1] = 16'h03C3;
        start_a = 1'b1;
        wait_dv_a(100, ok);
        n_tests++; if (data_a !== 32'h03C3_05A5) begin n_fail++; $display("FAIL rmid_first_data: got %h want 03c305a5", data_a); end
        falls = 0; hit = 1'b0; prev = sck_a;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_100);
            if (prev && !sck_a) falls++;
            prev = sck_a;
            if (falls == 4 && sck_a) begin reset = 1'b1; hit = 1'b1; break; end
        end
        n_tests++; if (!hit) begin n_fail++; $display("FAIL rmid_sync: got %0d falls want 4", falls); end
        @(negedge clk_100);
        n_tests++; if (cs_a !== 1'b1 || sck_a !== 1'b0) begin n_fail++; $display("FAIL rmid_pins: got cs=%b sck=%b want cs=1 sck=0", cs_a, sck_a); end
        n_tests++; if (dv_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL rmid_ctrl: got dv=%b busy=%b want 0 0", dv_a, busy_a); end
        n_tests++; if (data_a !== 32'h0 || trig_a !== 2'b00) begin n_fail++; $display("FAIL rmid_outputs: got %h/%b want 0/00", data_a, trig_a); end
        word_a[0] = 16'h0001; word_a[1] = 16'h0FFF;
        reset = 1'b0;
        wait_dv_a(100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_dv_timeout: got none want data_valid"); end
        n_tests++; if (data_a !== 32'h0FFF_0001) begin n_fail++; $display("FAIL rmid_data: got %h want 0fff0001", data_a); end
        start_a = 1'b0;
    endtask

    initial begin
        word_a[0] = '0; word_a[1] = '0;
        word_b[0] = '0; word_b[1] = '0;
        test_reset();
        test_basic();
        test_div3();
        test_trigger();
        test_stop_mid();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
